// File: rtl/game_clk_pkg.sv
// Shared timing constants for the game clocking block.
// The board clock rate, the VGA pixel rate and the speed-up input width live here.
package game_clk_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int PIX_HZ      = 25_000_000;
    localparam int DEFAULT_DIV = CLK_HZ / 40;
    localparam int SPEED_W     = 2;

endpackage

// File: rtl/tick_channel.sv
// One game-update tick channel.
// It holds a programmable divisor, a modulo counter, a one-cycle tick and a toggling level.
module tick_channel #(
    parameter int CNT_W       = 22,
    parameter int DEFAULT_DIV = game_clk_pkg::DEFAULT_DIV
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             we,
    input  logic                             pause,
    input  logic [game_clk_pkg::SPEED_W-1:0] speed,
    input  logic [CNT_W-1:0]                 div_in,
    output logic                             tick,
    output logic                             level
);
    import game_clk_pkg::*;

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_shift;
    logic [CNT_W-1:0] div_eff;
    logic [CNT_W-1:0] last;

    // The clamp happens before the subtraction, so last can never underflow.
    always_comb begin
        div_shift = div_q >> speed;
        div_eff   = (div_shift == '0) ? CNT_W'(1) : div_shift;
        last      = div_eff - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= CNT_W'(DEFAULT_DIV);
            cnt_q <= '0;
            tick  <= 1'b0;
            level <= 1'b0;
        end else if (we) begin
            div_q <= div_in;
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (pause) begin
            tick  <= 1'b0;
        end else if (cnt_q >= last) begin
            // >= rather than == so that a speed-up mid-count wraps at once.
            cnt_q <= '0;
            tick  <= 1'b1;
            level <= ~level;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/game_tick_gen.sv
// Game timing generator: the VGA pixel clock-enable plus NUM_CH programmable tick channels.
// All outputs are enables in the board clock domain.
module game_tick_gen #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 22,
    parameter int PIX_DIV     = 2,
    parameter int DEFAULT_DIV = game_clk_pkg::DEFAULT_DIV,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             pause_i,
    input  logic [game_clk_pkg::SPEED_W-1:0] speed_i,
    input  logic                             cfg_we_i,
    input  logic [CH_W-1:0]                  cfg_ch_i,
    input  logic [CNT_W-1:0]                 cfg_div_i,
    output logic                             pix_ce_o,
    output logic [NUM_CH-1:0]                tick_o,
    output logic [NUM_CH-1:0]                level_o
);
    import game_clk_pkg::*;

    localparam int PIX_W = $clog2(PIX_DIV);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_DIV - 1);

    logic [PIX_W-1:0] pix_cnt;

    // The pixel enable ignores pause, speed and configuration writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            pix_ce_o <= 1'b0;
        end else if (pix_cnt == PIX_LAST) begin
            pix_cnt  <= '0;
            pix_ce_o <= 1'b1;
        end else begin
            pix_cnt  <= pix_cnt + PIX_W'(1);
            pix_ce_o <= 1'b0;
        end
    end

    // An out-of-range channel index matches no channel, so the write is dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_we;

        assign ch_we = cfg_we_i && (cfg_ch_i == CH_W'(i));

        tick_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_channel (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (ch_we),
            .pause (pause_i),
            .speed (speed_i),
            .div_in(cfg_div_i),
            .tick  (tick_o[i]),
            .level (level_o[i])
        );
    end

endmodule

// File: tb/tb_game_tick_gen.sv
// Self-checking bench for game_tick_gen using a table of directed vectors.
// A second three-channel instance shows that an out-of-range channel write is ignored.
module tb_game_tick_gen;

    typedef struct {
        logic       rst_n;
        logic       pause;
        logic [1:0] speed;
        logic       we;
        logic [1:0] ch;
        logic [7:0] div;
        logic [1:0] tick;
        logic [1:0] level;
        int         test_id;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pause;
    logic [1:0] speed;
    logic       cfg_we;
    logic [0:0] cfg_ch;
    logic       cfg_we3;
    logic [1:0] cfg_ch3;
    logic [7:0] cfg_div;
    logic       pix_ce;
    logic [1:0] tick;
    logic [1:0] level;
    logic       pix_ce3;
    logic [2:0] tick3;
    logic [2:0] level3;

    vec_t vecs[$];
    int   edge_n;
    int   n_tests;
    int   n_fail;

    always #5 clk = ~clk;

    game_tick_gen #(
        .NUM_CH(2), .CNT_W(8), .PIX_DIV(2), .DEFAULT_DIV(5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pause_i  (pause),
        .speed_i  (speed),
        .cfg_we_i (cfg_we),
        .cfg_ch_i (cfg_ch),
        .cfg_div_i(cfg_div),
        .pix_ce_o (pix_ce),
        .tick_o   (tick),
        .level_o  (level)
    );

    // Three channels give cfg_ch a 2-bit index, so index 3 is out of range.
    game_tick_gen #(
        .NUM_CH(3), .CNT_W(8), .PIX_DIV(2), .DEFAULT_DIV(5)
    ) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .pause_i  (pause),
        .speed_i  (speed),
        .cfg_we_i (cfg_we3),
        .cfg_ch_i (cfg_ch3),
        .cfg_div_i(cfg_div),
        .pix_ce_o (pix_ce3),
        .tick_o   (tick3),
        .level_o  (level3)
    );

    function automatic void add(input logic r, input logic p, input logic [1:0] sp,
                                input logic we, input logic [1:0] ch, input logic [7:0] dv,
                                input logic [1:0] t, input logic [1:0] l, input int id);
        vec_t v;
        v.rst_n = r; v.pause = p; v.speed = sp; v.we = we; v.ch = ch; v.div = dv;
        v.tick = t; v.level = l; v.test_id = id;
        vecs.push_back(v);
    endfunction

    function automatic void add_idle(input int k, input int id);
        add(1, 0, 0, 0, 0, 0, (k % 5 == 0) ? 2'b11 : 2'b00, ((k / 5) % 2 == 1) ? 2'b11 : 2'b00, id);
    endfunction

    function automatic void add_reset(input int id);
        add(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, id);
    endfunction

    task automatic apply_stimulus(input vec_t v);
        rst_n   = v.rst_n;
        pause   = v.pause;
        speed   = v.speed;
        cfg_div = v.div;
        cfg_we  = v.we && (v.ch < 2'd2);
        cfg_ch  = v.ch[0];
        cfg_we3 = v.we;
        cfg_ch3 = v.ch;
        @(posedge clk);
        #1;
        if (!v.rst_n) edge_n = 0;
        else          edge_n++;
    endtask

    task automatic compare(input string name, input int id, input int idx,
                           input logic [1:0] act, input logic [1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL test%0d vec%0d %s: got %b expected %b", id, idx, name, act, exp);
        end
    endtask

    task automatic check_output(input vec_t v, input int idx);
        logic [1:0] exp_pix;
        exp_pix = {1'b0, (v.rst_n && (edge_n % 2 == 0))};
        compare("pix_ce",  v.test_id, idx, {1'b0, pix_ce},  exp_pix);
        compare("tick",    v.test_id, idx, tick,            v.tick);
        compare("level",   v.test_id, idx, level,           v.level);
        compare("pix_ce3", v.test_id, idx, {1'b0, pix_ce3}, exp_pix);
        compare("tick3",   v.test_id, idx, tick3[1:0],      v.tick);
        compare("level3",  v.test_id, idx, level3[1:0],     v.level);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        edge_n  = 0;

        // Test 1: idle after reset, default divisor of 5 on both channels.
        add_reset(1); add_reset(1);
        for (int k = 1; k <= 20; k++) add_idle(k, 1);

        // Test 2: speed 1 halves the divisor, speed 3 clamps it to 1.
        add_reset(2); add_reset(2);
        for (int k = 1; k <= 6; k++)
            add(1, 0, 1, 0, 0, 0, (k % 2 == 0) ? 2'b11 : 2'b00,
                (((k / 2) % 2) == 1) ? 2'b11 : 2'b00, 2);
        add(1, 0, 3, 0, 0, 0, 2'b11, 2'b00, 2);
        add(1, 0, 3, 0, 0, 0, 2'b11, 2'b11, 2);
        add(1, 0, 3, 0, 0, 0, 2'b11, 2'b00, 2);
        add(1, 0, 3, 0, 0, 0, 2'b11, 2'b11, 2);

        // Test 3: write ch1 on its tick edge; write wins, ch0 keeps its phase.
        add_reset(3);
        for (int k = 1; k <= 4; k++) add_idle(k, 3);
        add(1, 0, 0, 1, 1, 3, 2'b01, 2'b01, 3);
        add(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 3);
        add(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 3);
        add(1, 0, 0, 0, 0, 0, 2'b10, 2'b11, 3);
        add(1, 0, 0, 0, 0, 0, 2'b00, 2'b11, 3);
        add(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 3);
        add(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3);
        add(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3);
        add(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3);
        add(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 3);
        add(1, 0, 0, 0, 0, 0, 2'b01, 2'b11, 3);

        // Test 4: pause for 7 edges with the count at 2; the tick slips by 7.
        add_reset(4);
        add_idle(1, 4); add_idle(2, 4);
        for (int k = 3; k <= 9; k++) add(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4);
        add(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4);
        add(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4);
        add(1, 0, 0, 0, 0, 0, 2'b11, 2'b11, 4);
        add(1, 0, 0, 0, 0, 0, 2'b00, 2'b11, 4);

        // Test 5: speed 0->2 with the count at 3 wraps on the next edge.
        add_reset(5);
        for (int k = 1; k <= 3; k++) add_idle(k, 5);
        add(1, 0, 2, 0, 0, 0, 2'b11, 2'b11, 5);
        for (int k = 5; k <= 8; k++) add(1, 0, 0, 0, 0, 0, 2'b00, 2'b11, 5);
        add(1, 0, 0, 0, 0, 0, 2'b11, 2'b00, 5);
        add(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 5);

        // Test 6: reset mid-count restores divisors; index 3 write on dut3 is ignored.
        add_reset(6);
        add(1, 0, 0, 1, 0, 3, 2'b00, 2'b00, 6);
        add(1, 0, 0, 1, 1, 7, 2'b00, 2'b00, 6);
        add(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 6);
        add_reset(6);
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) add(1, 0, 0, 1, 3, 1, 2'b00, 2'b00, 6);
            else        add_idle(k, 6);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i], i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
